// File: rtl/svmcoeff_ctrl_if.sv
// rtl/svmcoeff_ctrl_if.sv - coefficient RAM port bundle between svmcoeff_ctrl and its dual-port RAM
interface svmcoeff_ctrl_if #(
    parameter int CWIDTH = 9,
    parameter int AWIDTH = 11
);
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [CWIDTH-1:0] mem_wdata;
    logic [AWIDTH-1:0] mem_raddr;
    logic [CWIDTH-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_waddr,
        output mem_wdata,
        output mem_raddr,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/svmcoeff_ctrl.sv
// rtl/svmcoeff_ctrl.sv - SVM coefficient download and read sequencer feeding svmrow_mem
module svmcoeff_ctrl #(
    parameter int CWIDTH    = 9,
    parameter int BLOCKSIZE = 16,
    parameter int WINCOLS   = 8,
    parameter int WINROWS   = 16,
    parameter int WPI       = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_start,
    input  logic                       load_dv,
    input  logic [CWIDTH-1:0]          load_data,
    input  logic                       frame_start,
    input  logic                       dvi_in,
    input  logic [$clog2(WPI)-1:0]     wincount,
    svmcoeff_ctrl_if.master            ram,
    output logic [CWIDTH-1:0]          svcoeff_out,
    output logic                       dvi_en,
    output logic [$clog2(WINROWS)-1:0] line_cnt,
    output logic                       loaded,
    output logic                       frame_done,
    output logic                       err_sticky
);
    localparam int NCOEF  = BLOCKSIZE * WINCOLS * WINROWS;
    localparam int AWIDTH = $clog2(NCOEF);
    localparam int BLK    = BLOCKSIZE * WINCOLS;
    localparam int BW     = $clog2(BLK);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(NCOEF - 1);
    localparam logic [BW-1:0]     LAST_COL = BW'(BLK - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]        state;
    logic [AWIDTH-1:0] waddr;
    logic [AWIDTH-1:0] ridx;
    logic [BW-1:0]     col;
    logic              we_q;
    logic [AWIDTH-1:0] waddr_q;
    logic [CWIDTH-1:0] wdata_q;
    logic              cons;

    assign cons = dvi_in && (wincount == '0);

    // ridx is itself the registered read address, so the RAM output for a new
    // index lands one cycle later, ahead of the next window's consume.
    assign ram.mem_we    = we_q;
    assign ram.mem_waddr = waddr_q;
    assign ram.mem_wdata = wdata_q;
    assign ram.mem_raddr = ridx;
    assign svcoeff_out   = ram.mem_rdata;
    assign dvi_en        = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            waddr      <= '0;
            ridx       <= '0;
            col        <= '0;
            line_cnt   <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            loaded     <= 1'b0;
            frame_done <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state  <= S_LOAD;
                        waddr  <= '0;
                        loaded <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        waddr <= '0;
                    end else if (load_dv) begin
                        we_q    <= 1'b1;
                        wdata_q <= load_data;
                        waddr_q <= waddr;
                        if (waddr == LAST_IDX) begin
                            waddr  <= '0;
                            state  <= S_READY;
                            loaded <= 1'b1;
                        end else begin
                            waddr <= waddr + 1'b1;
                        end
                    end
                    if (frame_start) begin
                        err_sticky <= 1'b1;
                    end
                end
                S_READY: begin
                    if (load_start) begin
                        state  <= S_LOAD;
                        waddr  <= '0;
                        loaded <= 1'b0;
                    end else if (frame_start) begin
                        state    <= S_RUN;
                        ridx     <= '0;
                        col      <= '0;
                        line_cnt <= '0;
                    end
                end
                default: begin
                    if (frame_start) begin
                        ridx       <= '0;
                        col        <= '0;
                        line_cnt   <= '0;
                        err_sticky <= 1'b1;
                    end else if (cons) begin
                        if (ridx == LAST_IDX) begin
                            ridx       <= '0;
                            col        <= '0;
                            line_cnt   <= '0;
                            frame_done <= 1'b1;
                            state      <= S_READY;
                        end else begin
                            ridx <= ridx + 1'b1;
                            if (col == LAST_COL) begin
                                col      <= '0;
                                line_cnt <= line_cnt + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                    if (load_start) begin
                        err_sticky <= 1'b1;
                    end
                end
            endcase
            if (cons && (state != S_RUN)) begin
                err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_svmcoeff_ctrl.sv
// tb/tb_svmcoeff_ctrl.sv - scoreboard bench for svmcoeff_ctrl in the 2x2x2, WPI=2 configuration
module tb_svmcoeff_ctrl;
    localparam int CW  = 9;
    localparam int NC  = 8;
    localparam int AW  = 3;
    localparam int BLK = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_start = 1'b0;
    logic          load_dv = 1'b0;
    logic [CW-1:0] load_data = '0;
    logic          frame_start = 1'b0;
    logic          dvi_in = 1'b0;
    logic [0:0]    wincount = '0;
    logic [CW-1:0] svcoeff_out;
    logic          dvi_en;
    logic [0:0]    line_cnt;
    logic          loaded;
    logic          frame_done;
    logic          err_sticky;

    svmcoeff_ctrl_if #(.CWIDTH(CW), .AWIDTH(AW)) ram_bus ();

    svmcoeff_ctrl #(
        .CWIDTH(CW), .BLOCKSIZE(2), .WINCOLS(2), .WINROWS(2), .WPI(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_dv(load_dv),
        .load_data(load_data), .frame_start(frame_start), .dvi_in(dvi_in),
        .wincount(wincount), .ram(ram_bus), .svcoeff_out(svcoeff_out),
        .dvi_en(dvi_en), .line_cnt(line_cnt), .loaded(loaded),
        .frame_done(frame_done), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] ram_arr [NC];
    always @(posedge clk) begin
        if (ram_bus.mem_we) ram_arr[ram_bus.mem_waddr] <= ram_bus.mem_wdata;
        ram_bus.mem_rdata <= ram_arr[ram_bus.mem_raddr];
    end

    typedef struct { logic [AW-1:0] a; logic [CW-1:0] d; } wexp_t;
    typedef struct { logic [CW-1:0] c; int line; bit last; } cexp_t;

    wexp_t wq[$];
    cexp_t cq[$];
    logic [CW-1:0] model [NC];
    logic [CW-1:0] set_buf [NC];
    int  pos = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    bit  mon_on = 1'b0;
    bit  fd_arm = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic fail(input string name, input logic [31:0] got);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, got, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cons();
        cexp_t e;
        e.c = model[pos];
        e.line = pos / BLK;
        e.last = (pos == NC - 1);
        cq.push_back(e);
        pos = (pos + 1) % NC;
    endtask

    task automatic load_set();
        wexp_t w;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("loaded_during_load", loaded, 0);
        for (int i = 0; i < NC; i++) begin
            repeat ($urandom_range(0, 2)) cyc();
            load_dv = 1'b1;
            load_data = set_buf[i];
            w.a = AW'(i);
            w.d = set_buf[i];
            wq.push_back(w);
            cyc();
            load_dv = 1'b0;
        end
        chk("loaded_after_last", loaded, 1);
        for (int i = 0; i < NC; i++) model[i] = set_buf[i];
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        pos = 0;
        cyc();
    endtask

    task automatic pixel_pair(input bit expect_run);
        dvi_in = 1'b1;
        wincount = 1'b0;
        if (expect_run) push_cons();
        cyc();
        wincount = 1'b1;
        cyc();
        dvi_in = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic rand_set();
        for (int i = 0; i < NC; i++) set_buf[i] = CW'($urandom_range(0, (1 << CW) - 1));
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (ram_bus.mem_we) begin
                if (wq.size() == 0) begin
                    fail("write_unexpected", {ram_bus.mem_waddr, ram_bus.mem_wdata});
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("mem_waddr", ram_bus.mem_waddr, w.a);
                    chk("mem_wdata", ram_bus.mem_wdata, w.d);
                end
            end
            if (fd_arm || frame_done) begin
                chk("frame_done", frame_done, fd_arm);
                if (fd_arm) chk("dvi_en_after_done", dvi_en, 0);
            end
            fd_arm = 1'b0;
            if (dvi_en && dvi_in && wincount == 1'b0) begin
                if (cq.size() == 0) begin
                    fail("consume_unexpected", svcoeff_out);
                end else begin
                    cexp_t e;
                    e = cq.pop_front();
                    chk("svcoeff_out", svcoeff_out, e.c);
                    chk("line_cnt", line_cnt, e.line);
                    fd_arm = e.last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        chk("rst_dvi_en", dvi_en, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_mem_we", ram_bus.mem_we, 0);
        chk("rst_mem_raddr", ram_bus.mem_raddr, 0);
        reset_n = 1'b1;
        mon_on = 1'b1;
        cyc();

        for (int i = 0; i < NC; i++) set_buf[i] = CW'(i - 4);
        load_set();
        chk("ready_dvi_en", dvi_en, 0);
        chk("ready_err", err_sticky, 0);

        start_frame();
        chk("run_dvi_en", dvi_en, 1);
        repeat (NC) pixel_pair(1'b1);
        repeat (2) cyc();
        chk("done_dvi_en", dvi_en, 0);
        chk("done_err", err_sticky, 0);
        chk("done_line_cnt", line_cnt, 0);

        // misuse: consume in READY, stray load_dv, load_start during RUN
        pixel_pair(1'b0);
        chk("misuse_err", err_sticky, 1);
        load_dv = 1'b1;
        load_data = CW'($urandom);
        cyc();
        load_dv = 1'b0;
        start_frame();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("load_in_run_dvi_en", dvi_en, 1);
        chk("load_in_run_loaded", loaded, 1);
        repeat (NC) pixel_pair(1'b1);
        repeat (2) cyc();

        // resync after five consumes on a random set
        rand_set();
        load_set();
        start_frame();
        repeat (5) pixel_pair(1'b1);
        start_frame();
        chk("resync_line_cnt", line_cnt, 0);
        chk("resync_err", err_sticky, 1);
        chk("resync_dvi_en", dvi_en, 1);
        repeat (NC) pixel_pair(1'b1);
        repeat (2) cyc();

        // load_start beats frame_start in READY
        load_start = 1'b1;
        frame_start = 1'b1;
        cyc();
        load_start = 1'b0;
        frame_start = 1'b0;
        chk("prec_dvi_en", dvi_en, 0);
        chk("prec_loaded", loaded, 0);
        cyc();
        chk("prec_dvi_en_later", dvi_en, 0);
        rand_set();
        load_set();
        start_frame();
        repeat (NC) pixel_pair(1'b1);
        repeat (2) cyc();

        // reset in the middle of a download
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wexp_t w;
            load_dv = 1'b1;
            load_data = CW'($urandom);
            w.a = AW'(i);
            w.d = load_data;
            wq.push_back(w);
            cyc();
            load_dv = 1'b0;
        end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("midrst_loaded", loaded, 0);
        chk("midrst_err", err_sticky, 0);
        chk("midrst_dvi_en", dvi_en, 0);
        chk("midrst_line_cnt", line_cnt, 0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("idle_frame_start_dvi_en", dvi_en, 0);
        load_dv = 1'b1;
        cyc();
        load_dv = 1'b0;
        repeat (3) cyc();
        chk("idle_loaded", loaded, 0);

        chk("cons_queue_empty", cq.size(), 0);
        chk("write_queue_empty", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
